// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32 M-extension execute unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } mdop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [6:0] MD_OPCODE = 7'b0110011;
    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

    // Returns {a_signed, b_signed} for an M-op.
    function automatic logic [1:0] md_signs(input mdop_e op);
        case (op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: return 2'b11;
            MD_MULHSU:                       return 2'b10;
            default:                         return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {acc, shreg}: shift-add for multiply, restoring subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] shreg,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] shreg_nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] rem_sub;
    logic            fits;

    always_comb begin
        sum     = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        shifted = {acc, shreg[XLEN-1]};
        fits    = (shifted >= {1'b0, operand});
        // Only used when fits, so the dropped top bit is always zero.
        rem_sub = shifted[XLEN-1:0] - operand;
        if (is_div) begin
            acc_nxt   = fits ? rem_sub : shifted[XLEN-1:0];
            shreg_nxt = {shreg[XLEN-2:0], fits};
        end else begin
            acc_nxt   = sum[XLEN:1];
            shreg_nxt = {sum[0], shreg[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32 M-extension unit: XLEN-cycle radix-2 mul/div with pipeline stall and sign fix-up.
//  state | meaning
//  IDLE  | waiting for an M-op; captures operands on start_i
//  BUSY  | one multiply/divide step per cycle, count runs down to 0
//  DONE  | done_o pulse, result_o valid; returns to IDLE
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state, state_nxt;
    mdop_e           op_q, op_in;
    logic            sa_q, sb_q, sa_in, sb_in;
    logic [1:0]      signs_in;
    logic [XLEN-1:0] amag_in, bmag_in, bmag_q;
    logic [XLEN-1:0] acc_q, shreg_q, acc_nxt, shreg_nxt;
    logic [CW-1:0]   count_q;
    logic            capture, special, div_zero, div_ovf;
    logic [XLEN-1:0] special_result, final_result;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        op_in    = mdop_e'(funct3_i);
        signs_in = md_signs(op_in);
        sa_in    = signs_in[1] & op_a_i[XLEN-1];
        sb_in    = signs_in[0] & op_b_i[XLEN-1];
        amag_in  = sa_in ? -op_a_i : op_a_i;
        bmag_in  = sb_in ? -op_b_i : op_b_i;
        div_zero = (op_b_i == '0);
        div_ovf  = signs_in[0] & (op_a_i == INT_MIN) & (op_b_i == '1);
        special  = funct3_i[2] & (div_zero | div_ovf);
        if (div_zero)
            special_result = funct3_i[1] ? op_a_i : '1;
        else
            special_result = funct3_i[1] ? '0 : INT_MIN;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div    (op_q[2]),
        .acc       (acc_q),
        .shreg     (shreg_q),
        .operand   (bmag_q),
        .acc_nxt   (acc_nxt),
        .shreg_nxt (shreg_nxt)
    );

    always_comb begin
        prod   = {acc_nxt, shreg_nxt};
        prod_s = (sa_q ^ sb_q) ? -prod : prod;
        case (op_q)
            MD_MUL:                       final_result = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_result = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              final_result = (sa_q ^ sb_q) ? -shreg_nxt : shreg_nxt;
            default:                      final_result = sa_q ? -acc_nxt : acc_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: if (start_i) begin
                capture   = 1'b1;
                state_nxt = special ? DONE : BUSY;
            end
            BUSY: if (count_q == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill_i) begin
            state_nxt = IDLE;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= MD_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bmag_q   <= '0;
            acc_q    <= '0;
            shreg_q  <= '0;
            count_q  <= '0;
            result_o <= '0;
        end else if (capture) begin
            op_q    <= op_in;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            bmag_q  <= bmag_in;
            acc_q   <= '0;
            shreg_q <= amag_in;
            count_q <= CNT_LAST;
            if (special) result_o <= special_result;
        end else if (state == BUSY && !kill_i) begin
            acc_q   <= acc_nxt;
            shreg_q <= shreg_nxt;
            count_q <= count_q - 1'b1;
            if (count_q == '0) result_o <= final_result;
        end
    end

    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DONE);
    assign stall_o = start_i & (state != DONE);

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed self-checking bench for muldiv_seq_unit: latency, stall length, results, kill and reset.
module tb_muldiv_seq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_seq_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .kill_i   (kill),
        .funct3_i (funct3),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .stall_o  (stall),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one M-op, holds start until done, checks result, latency and stall length.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit scramble);
        int          lat = 0;
        int          st = 0;
        bit          got = 0;
        logic [31:0] res = '0;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (stall) st++;
            if (done) begin
                got = 1'b1;
                res = result;
                break;
            end
            if (scramble && k == 3) begin
                op_a = $urandom;
                op_b = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        chk({tag, "_result"}, res, exp);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_stall"}, st, exp_lat);
    endtask

    initial begin
        int pulses;

        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;

        run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
        @(negedge clk); #1;
        chk("mul_hold_result", result, 32'hFFFFFFEB);
        chk("mul_done_pulse", {31'd0, done}, 32'd0);

        run_op("mul_m5_m6", 3'b000, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30, 33, 1'b0);
        run_op("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
        run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
        run_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b0);
        run_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b0);
        run_op("div_7_m2", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b0);
        run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33, 1'b0);
        run_op("divu_min_3", 3'b101, 32'h80000000, 32'd3, 32'h2AAAAAAA, 33, 1'b0);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        run_op("divu_scramble", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        run_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        run_op("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);

        // Kill a DIV in its 11th cycle; the previous result must survive.
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0; start = 1'b0;
        #1;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_done", {31'd0, done}, 32'd0);
        chk("kill_result_kept", result, 32'h80000000);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (done) pulses++;
        end
        chk("kill_no_done", pulses, 0);
        run_op("mul_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);

        // Reset in the middle of a MULHU.
        @(negedge clk);
        funct3 = 3'b011; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; start = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (done) pulses++;
        end
        chk("rst_no_done", pulses, 0);

        run_op("b2b_divu", 3'b101, 32'd1000, 32'd10, 32'd100, 33, 1'b0);
        run_op("b2b_mul", 3'b000, 32'h12345678, 32'h10, 32'h23456780, 33, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
